// File: rtl/mu0_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported MU0 memory.
// Optional build macro MU0_ARB_LOCK_EN adds lock0/lock1 so an owner can keep the memory.
module mu0_mem_arbiter #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [11:0] addr0,
    input  logic [11:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
`ifdef MU0_ARB_LOCK_EN
    input  logic        lock0,
    input  logic        lock1,
`endif
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic [1:0]  gnt,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  wait_cnt;
    logic [1:0]  gnt_q;
    logic        last_q;      // 1 when requester 1 was granted last
    logic        we_q;
    logic [11:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        elig0, elig1, win1;
`ifdef MU0_ARB_LOCK_EN
    logic        locked_q;
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        elig0 = req0;
        elig1 = req1;
`ifdef MU0_ARB_LOCK_EN
        if (locked_q) begin
            elig0 = req0 & ~last_q;
            elig1 = req1 & last_q;
        end
`endif
        win1     = elig1 & (~elig0 | ~last_q);
        state_nx = state;
        case (state)
            IDLE:    if (elig0 | elig1) state_nx = ACCESS;
            ACCESS:  if (wait_cnt == 3'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q    <= 2'b00;
            wait_cnt <= 3'd0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 12'd0;
            wdata_q  <= 16'd0;
            rdata_q  <= 16'd0;
`ifdef MU0_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        gnt_q    <= win1 ? 2'b10 : 2'b01;
                        we_q     <= win1 ? we1 : we0;
                        addr_q   <= win1 ? addr1 : addr0;
                        wdata_q  <= win1 ? wdata1 : wdata0;
                        wait_cnt <= 3'(MEM_WAIT);
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        last_q <= gnt_q[1];
                        if (!we_q) rdata_q <= mem_rdata;
                    end
                end
                RESP: begin
                    gnt_q <= 2'b00;
`ifdef MU0_ARB_LOCK_EN
                    locked_q <= gnt_q[1] ? lock1 : lock0;
`endif
                end
                default: gnt_q <= 2'b00;
            endcase
        end
    end

    // Enables and bus are decoded from state so a reset drops them without waiting for an edge.
    assign ack0      = (state == RESP) & gnt_q[0];
    assign ack1      = (state == RESP) & gnt_q[1];
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign mem_rd    = (state == ACCESS) & ~we_q;
    assign mem_wr    = (state == ACCESS) & we_q;
    assign mem_addr  = (state == ACCESS) ? addr_q : 12'd0;
    assign mem_wdata = (state == ACCESS) ? wdata_q : 16'd0;

endmodule

// File: doc/mu0_mem_arbiter.md
MU0_MEM_ARBITER -- requirements
Module: mu0_mem_arbiter

Interface
REQ-001 Parameter MEM_WAIT, default 0, range 0-7: extra memory wait cycles per access.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0, req1  input  1 each  access request from requester 0 and 1.
REQ-005 we0, we1  input  1 each  1 = write, 0 = read; valid while reqN high.
REQ-006 addr0, addr1  input  12 each  word address.
REQ-007 wdata0, wdata1  input  16 each  write data.
REQ-008 ack0, ack1  output  1 each  one-cycle completion pulse per requester.
REQ-009 rdata  output  16  read data; valid while ackN high.
REQ-010 gnt  output  2  one-hot owner; 00 when idle.
REQ-011 mem_addr  output  12  shared memory address.
REQ-012 mem_wdata  output  16  shared memory write data.
REQ-013 mem_rd, mem_wr  output  1 each  memory read and write enables.
REQ-014 mem_rdata  input  16  memory read data; valid in the final ACCESS cycle.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP.
- IDLE -> ACCESS when any eligible reqN is high.
- ACCESS -> RESP when the wait counter is 0.
- RESP -> IDLE unconditionally.
REQ-016 The IDLE->ACCESS edge registers the winner's addr, we and wdata, sets gnt, and loads the wait counter with MEM_WAIT.
REQ-017 Arbitration is round-robin:
- sole requester wins;
- if both request, the requester not granted last wins;
- the last-granted register updates on entry to RESP.
REQ-018 In ACCESS:
- mem_addr and mem_wdata come from the registered values;
- mem_rd = ~we_q and mem_wr = we_q;
- the counter decrements each cycle while nonzero.
REQ-019 Outside ACCESS: mem_rd = mem_wr = 0, mem_addr = 0, mem_wdata = 0.
REQ-020 The ACCESS->RESP edge captures mem_rdata into rdata for reads; for writes, rdata keeps its prior value.
REQ-021 In RESP, ack of the owner is high for exactly one cycle and the other ack stays 0.
REQ-022 Latency: request sampled in IDLE at cycle T -> ack high at cycle T+2+MEM_WAIT.
REQ-023 Memory enables are high for exactly MEM_WAIT+1 consecutive cycles per access.
REQ-024 Requester handshake:
- reqN and its operands are held stable until ackN is seen;
- reqN is dropped, or a new request presented, on the edge that samples ackN.
REQ-025 Requests arriving during ACCESS or RESP are not lost; they are sampled on the next IDLE cycle.
REQ-026 Back-to-back throughput: one access per 3+MEM_WAIT cycles.
REQ-027 ack0 and ack1 are never high simultaneously; gnt is never 11.

Reset
REQ-028 rst forces, asynchronously:
- state IDLE, gnt = 00, ack0 = ack1 = 0;
- mem_rd = mem_wr = 0, rdata = 0, wait counter = 0;
- last-granted = 1, so requester 0 wins the first tie.
REQ-029 rst asserted during ACCESS or RESP aborts the access: no ack is issued and memory enables drop immediately.

Configuration
REQ-030 Macro MU0_ARB_LOCK_EN, when defined:
- adds inputs lock0 and lock1 (1 bit each);
- if the owner's lockN is high in RESP, a locked flag is set and only that requester is eligible in IDLE;
- the flag clears at any RESP where the owner's lockN is low;
- rst clears the flag.
REQ-031 Without MU0_ARB_LOCK_EN: no lock ports and pure round-robin per REQ-017.

Verification
REQ-032 MEM_WAIT=0; req0 read addr 0x010 at cycle 1; mem_rdata=0x1234 -> mem_rd high cycle 2 only, ack0 and rdata=0x1234 at cycle 3.
REQ-033 MEM_WAIT=2; req1 write addr 0xFFF, data 0xBEEF -> mem_wr high cycles 2-4 with mem_addr=0xFFF; ack1 at cycle 5; rdata unchanged.
REQ-034 req0 and req1 held continuously, MEM_WAIT=0 -> grants alternate 0,1,0,1 starting with 0; one ack every 3 cycles.
REQ-035 rst pulsed during ACCESS of a req0 read -> no ack0; gnt=00 and mem_rd=0 immediately; next req1 is granted first-come.
REQ-036 MU0_ARB_LOCK_EN, lock0 high for 2 accesses, req1 continuous -> req0 wins 3 consecutive accesses, then req1.
